// File: rtl/hci_mem_rr_arbiter_pkg.sv
// Shared helpers for the hci memory round-robin arbiter.
package hci_mem_rr_arbiter_pkg;

  // Per-cycle outcome on the shared memory port.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_HS    = 2'd1,
    ARB_STALL = 2'd2
  } arb_ev_e;

  // Zero-width user fields are carried as one unused bit.
  function automatic int unsigned user_w(input int unsigned uw);
    return (uw > 0) ? uw : 1;
  endfunction

  // Round-robin successor of idx among n ports.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/hci_mem_intf.sv
// Minimal hci memory-side request/response interface.
interface hci_mem_intf
  import hci_mem_rr_arbiter_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned IW = 8,
  parameter int unsigned UW = 0
);
  localparam int unsigned UW_I = user_w(UW);

  logic              req;
  logic              gnt;
  logic [AW-1:0]     add;
  logic              wen;
  logic [DW-1:0]     data;
  logic [DW/8-1:0]   be;
  logic [IW-1:0]     id;
  logic [UW_I-1:0]   user;
  logic [DW-1:0]     r_data;
  logic [UW_I-1:0]   r_user;
  logic [IW-1:0]     r_id;

  modport master (
    output req, add, wen, data, be, id, user,
    input  gnt, r_data, r_user, r_id
  );

  modport slave (
    input  req, add, wen, data, be, id, user,
    output gnt, r_data, r_user, r_id
  );
endinterface

// File: rtl/hci_mem_rr_arbiter_prio_encoder.sv
// Rotating priority encoder: first set request at or after ptr_i, with wrap.
module hci_rr_prio_encoder #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  int unsigned      j;
  logic [IDX_W-1:0] j_idx;

  // Scan N positions starting at ptr_i; the first hit wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    j       = 0;
    j_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j     = (32'(ptr_i) + k) % N;
      j_idx = IDX_W'(j);
      if (!found_o && req_i[j_idx]) begin
        found_o = 1'b1;
        idx_o   = j_idx;
      end
    end
  end

endmodule

// File: rtl/hci_mem_rr_arbiter.sv
// Round-robin arbiter sharing one hci memory port among NB_REQ requesters.
// Request path is combinational; a stalled winner stays locked until it
// completes or withdraws; responses are steered back one cycle later.
module hci_mem_rr_arbiter
  import hci_mem_rr_arbiter_pkg::*;
#(
  parameter int unsigned NB_REQ = 4,
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned IW     = 8,
  parameter int unsigned UW     = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  hci_mem_intf.slave        tcdm_slave [NB_REQ],
  hci_mem_intf.master       tcdm_master,
  output logic [NB_REQ-1:0] r_valid_o
);

  localparam int unsigned IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int unsigned BW    = DW / 8;
  localparam int unsigned UW_I  = user_w(UW);

  // Requester fields flattened for indexed muxing.
  logic [NB_REQ-1:0]           s_req;
  logic [NB_REQ-1:0]           s_wen;
  logic [NB_REQ-1:0][AW-1:0]   s_add;
  logic [NB_REQ-1:0][DW-1:0]   s_data;
  logic [NB_REQ-1:0][BW-1:0]   s_be;
  logic [NB_REQ-1:0][IW-1:0]   s_id;
  logic [NB_REQ-1:0][UW_I-1:0] s_user;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_found;
  logic             lock_hit;
  logic [IDX_W-1:0] win_idx;
  logic             win_vld;
  arb_ev_e          ev;

  for (genvar i = 0; i < NB_REQ; i++) begin : g_slv
    assign s_req[i]  = tcdm_slave[i].req;
    assign s_wen[i]  = tcdm_slave[i].wen;
    assign s_add[i]  = tcdm_slave[i].add;
    assign s_data[i] = tcdm_slave[i].data;
    assign s_be[i]   = tcdm_slave[i].be;
    assign s_id[i]   = tcdm_slave[i].id;
    assign s_user[i] = tcdm_slave[i].user;

    assign tcdm_slave[i].gnt    = (win_idx == IDX_W'(i)) & s_req[i] & tcdm_master.gnt;
    assign tcdm_slave[i].r_data = tcdm_master.r_data;
    assign tcdm_slave[i].r_user = tcdm_master.r_user;
    assign tcdm_slave[i].r_id   = r_valid_o[i] ? tcdm_master.r_id : '0;

    assign r_valid_o[i] = rsp_valid_q & (rsp_idx_q == IDX_W'(i));
  end

  hci_rr_prio_encoder #(
    .N     (NB_REQ),
    .IDX_W (IDX_W)
  ) i_prio (
    .req_i   (s_req),
    .ptr_i   (ptr_q),
    .idx_o   (enc_idx),
    .found_o (enc_found)
  );

  // Winner: a still-requesting locked port beats the round-robin scan.
  always_comb begin
    lock_hit = lock_q & s_req[lock_idx_q];
    win_idx  = lock_hit ? lock_idx_q : enc_idx;
    win_vld  = lock_hit | enc_found;
    if (!win_vld)              ev = ARB_IDLE;
    else if (tcdm_master.gnt)  ev = ARB_HS;
    else                       ev = ARB_STALL;
  end

  // Drive the shared port from the winner, all-zero when nobody requests.
  always_comb begin
    tcdm_master.req  = 1'b0;
    tcdm_master.add  = '0;
    tcdm_master.wen  = 1'b0;
    tcdm_master.data = '0;
    tcdm_master.be   = '0;
    tcdm_master.id   = '0;
    tcdm_master.user = '0;
    if (win_vld) begin
      tcdm_master.req  = 1'b1;
      tcdm_master.add  = s_add[win_idx];
      tcdm_master.wen  = s_wen[win_idx];
      tcdm_master.data = s_data[win_idx];
      tcdm_master.be   = s_be[win_idx];
      tcdm_master.id   = s_id[win_idx];
      tcdm_master.user = s_user[win_idx];
    end
  end

  // Next state: advance on handshake, lock on stall, drop lock when idle.
  always_comb begin
    ptr_d       = ptr_q;
    lock_d      = 1'b0;
    lock_idx_d  = lock_idx_q;
    rsp_valid_d = 1'b0;
    rsp_idx_d   = rsp_idx_q;
    case (ev)
      ARB_HS: begin
        ptr_d       = IDX_W'(rr_next(32'(win_idx), NB_REQ));
        rsp_valid_d = 1'b1;
        rsp_idx_d   = win_idx;
      end
      ARB_STALL: begin
        lock_d     = 1'b1;
        lock_idx_d = win_idx;
      end
      default: ;
    endcase
  end

  // State registers; clear has the same effect as reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
    end else if (clear_i) begin
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q   <= rsp_idx_d;
    end
  end

endmodule

// File: tb/tb_hci_mem_rr_arbiter.sv
// Directed table-driven bench for hci_mem_rr_arbiter (NB_REQ=4 and NB_REQ=1).
module tb_hci_mem_rr_arbiter;

  logic clk = 1'b0;
  logic rst_i;
  logic clear_i;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int step   = 0;

  // NB_REQ=4 instance
  logic [3:0]  t_req;
  logic        t_mgnt;
  logic [31:0] t_rdata_m;
  logic [7:0]  t_rid_m;
  logic [31:0] t_add [4];
  logic [3:0]  s_gnt;
  logic [7:0]  s_rid [4];
  logic [31:0] s_rdata [4];
  logic [3:0]  rv;

  hci_mem_intf #(.AW(32), .DW(32), .IW(8), .UW(0)) slv [4] ();
  hci_mem_intf #(.AW(32), .DW(32), .IW(8), .UW(0)) mst ();

  for (genvar g = 0; g < 4; g++) begin : g_drv
    assign slv[g].req  = t_req[g];
    assign slv[g].add  = t_add[g];
    assign slv[g].wen  = (g % 2 == 1);
    assign slv[g].data = 32'hD0 + 32'(g);
    assign slv[g].be   = 4'hF;
    assign slv[g].id   = 8'h10 + 8'(g);
    assign slv[g].user = 1'b0;
    assign s_gnt[g]    = slv[g].gnt;
    assign s_rid[g]    = slv[g].r_id;
    assign s_rdata[g]  = slv[g].r_data;
  end
  assign mst.gnt    = t_mgnt;
  assign mst.r_data = t_rdata_m;
  assign mst.r_id   = t_rid_m;
  assign mst.r_user = 1'b0;

  hci_mem_rr_arbiter #(.NB_REQ(4), .AW(32), .DW(32), .IW(8), .UW(0)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .tcdm_slave  (slv),
    .tcdm_master (mst),
    .r_valid_o   (rv)
  );

  // NB_REQ=1 instance
  logic       t1_req, t1_gnt;
  logic       rv1;
  hci_mem_intf #(.AW(32), .DW(32), .IW(8), .UW(0)) slv1 [1] ();
  hci_mem_intf #(.AW(32), .DW(32), .IW(8), .UW(0)) mst1 ();
  assign slv1[0].req  = t1_req;
  assign slv1[0].add  = 32'h55;
  assign slv1[0].wen  = 1'b0;
  assign slv1[0].data = 32'h0;
  assign slv1[0].be   = 4'hF;
  assign slv1[0].id   = 8'h33;
  assign slv1[0].user = 1'b0;
  assign mst1.gnt     = t1_gnt;
  assign mst1.r_data  = 32'hCAFE;
  assign mst1.r_id    = 8'h77;
  assign mst1.r_user  = 1'b0;

  hci_mem_rr_arbiter #(.NB_REQ(1), .AW(32), .DW(32), .IW(8), .UW(0)) dut1 (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .tcdm_slave  (slv1),
    .tcdm_master (mst1),
    .r_valid_o   (rv1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, step, act, exp);
    end
  endtask

  // req/gnt/clr/rst applied; expected master req, winner, and r_valid_o
  // (which reflects the previous row's handshake).
  typedef struct {
    logic [3:0] req;
    logic       gnt;
    logic       clr;
    logic       rst;
    logic       mreq;
    int         win;
    logic [3:0] rv;
  } vec_t;
  vec_t tab[$];

  task automatic v(input logic [3:0] req, input logic gnt, input logic clr, input logic rst,
                   input logic mreq, input int win, input logic [3:0] exp_rv);
    vec_t e;
    e.req = req; e.gnt = gnt; e.clr = clr; e.rst = rst;
    e.mreq = mreq; e.win = win; e.rv = exp_rv;
    tab.push_back(e);
  endtask

  initial begin
    logic [3:0]  exp_gnt;
    logic [31:0] exp_add;
    logic [7:0]  exp_id;
    logic [31:0] exp_rid, act_rid;
    vec_t        e;

    rst_i = 1'b1; clear_i = 1'b0; t_req = '0; t_mgnt = 1'b0;
    t_rdata_m = '0; t_rid_m = '0; t1_req = 1'b0; t1_gnt = 1'b0;
    for (int i = 0; i < 4; i++) t_add[i] = 32'h100 ^ (32'(i ^ 2) << 4);

    // round robin, all requesting, memory always granting
    v(4'hF, 1, 0, 0, 1, 0, 4'b0000);
    v(4'hF, 1, 0, 0, 1, 1, 4'b0001);
    v(4'hF, 1, 0, 0, 1, 2, 4'b0010);
    v(4'hF, 1, 0, 0, 1, 3, 4'b0100);
    v(4'hF, 1, 0, 0, 1, 0, 4'b1000);
    v(4'hF, 1, 0, 0, 1, 1, 4'b0001);
    v(4'hF, 1, 0, 0, 1, 2, 4'b0010);
    v(4'hF, 1, 0, 0, 1, 3, 4'b0100);
    v(4'h0, 1, 0, 0, 0, 0, 4'b1000);
    // lone requester 2
    v(4'b0100, 1, 0, 0, 1, 2, 4'b0000);
    v(4'h0,    1, 0, 0, 0, 0, 4'b0100);
    // move pointer to 1, then 1 and 3 contend under 3 stall cycles
    v(4'b0001, 1, 0, 0, 1, 0, 4'b0000);
    v(4'b1010, 0, 0, 0, 1, 1, 4'b0001);
    v(4'b1010, 0, 0, 0, 1, 1, 4'b0000);
    v(4'b1010, 0, 0, 0, 1, 1, 4'b0000);
    v(4'b1010, 1, 0, 0, 1, 1, 4'b0000);
    v(4'b1000, 1, 0, 0, 1, 3, 4'b0010);
    v(4'h0,    1, 0, 0, 0, 0, 4'b1000);
    // lock beats pointer; locked 1 withdraws, 2 takes over the same cycle
    v(4'b0010, 0, 0, 0, 1, 1, 4'b0000);
    v(4'b0011, 0, 0, 0, 1, 1, 4'b0000);
    v(4'b0100, 0, 0, 0, 1, 2, 4'b0000);
    v(4'b0101, 1, 0, 0, 1, 2, 4'b0000);
    v(4'hF,    1, 0, 0, 1, 3, 4'b0100);
    v(4'h0,    1, 0, 0, 0, 0, 4'b1000);
    // clear coinciding with a handshake
    v(4'hF, 1, 0, 0, 1, 0, 4'b0000);
    v(4'hF, 1, 1, 0, 1, 1, 4'b0001);
    v(4'hF, 1, 0, 0, 1, 0, 4'b0000);
    v(4'h0, 1, 0, 0, 0, 0, 4'b0001);
    // pointer to 2, stall on 3, reset mid-stall restarts from 0
    v(4'b0010, 1, 0, 0, 1, 1, 4'b0000);
    v(4'b1011, 0, 0, 0, 1, 3, 4'b0010);
    v(4'b1011, 0, 0, 1, 1, 0, 4'b0000);
    v(4'hF,    1, 0, 0, 1, 0, 4'b0000);
    v(4'h0,    1, 0, 0, 0, 0, 4'b0001);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_rvalid", 64'(rv), 64'h0);
    chk("rst_mreq",   64'(mst.req), 64'h0);
    chk("rst_madd",   64'(mst.add), 64'h0);
    chk("rst_rvalid1", 64'(rv1), 64'h0);

    for (int s = 0; s < tab.size(); s++) begin
      e = tab[s];
      @(negedge clk);
      step = s + 1;
      t_req = e.req; t_mgnt = e.gnt; clear_i = e.clr; rst_i = e.rst;
      t_rdata_m = 32'hA500_0000 | 32'(s);
      t_rid_m   = 8'h80 | 8'(s);
      #1;
      exp_gnt = (e.mreq && e.gnt) ? (4'b0001 << e.win) : 4'b0000;
      exp_add = e.mreq ? t_add[e.win] : 32'h0;
      exp_id  = e.mreq ? (8'h10 + 8'(e.win)) : 8'h0;
      exp_rid = '0; act_rid = '0;
      for (int i = 0; i < 4; i++) begin
        exp_rid[i*8 +: 8] = e.rv[i] ? t_rid_m : 8'h0;
        act_rid[i*8 +: 8] = s_rid[i];
      end
      chk("mreq",   64'(mst.req), 64'(e.mreq));
      chk("madd",   64'(mst.add), 64'(exp_add));
      chk("mid",    64'(mst.id),  64'(exp_id));
      chk("gnt",    64'(s_gnt),   64'(exp_gnt));
      chk("rvalid", 64'(rv),      64'(e.rv));
      chk("r_id",   64'(act_rid), 64'(exp_rid));
      chk("r_data2", 64'(s_rdata[2]), 64'(t_rdata_m));
    end

    // single-requester instance: stall, handshake, response
    @(negedge clk);
    step = 100;
    t_req = '0; t1_req = 1'b1; t1_gnt = 1'b0; #1;
    chk("n1_mreq_stall", 64'(mst1.req), 64'h1);
    chk("n1_madd",       64'(mst1.add), 64'h55);
    chk("n1_gnt_stall",  64'(slv1[0].gnt), 64'h0);
    @(negedge clk);
    step = 101;
    t1_gnt = 1'b1; #1;
    chk("n1_gnt_hs",  64'(slv1[0].gnt), 64'h1);
    chk("n1_rv_hs",   64'(rv1), 64'h0);
    @(negedge clk);
    step = 102;
    t1_req = 1'b0; #1;
    chk("n1_rv_rsp",  64'(rv1), 64'h1);
    chk("n1_rid_rsp", 64'(slv1[0].r_id), 64'h77);
    chk("n1_mreq_idle", 64'(mst1.req), 64'h0);
    @(negedge clk); #1;
    chk("n1_rv_idle", 64'(rv1), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
